// File: rtl/hdd_host_xfer.sv
// hdd_host_xfer: moves one 512-byte block between a byte-stream block device
// and the HDD card's sector buffer, in answer to one-cycle hdd_read/hdd_write
// requests. busy holds the CPU while a command is in flight.
// Optional feature macro: HDD_XFER_TIMEOUT_EN adds a watchdog that aborts a
// stalled command with error=1 after TIMEOUT_CYCLES idle device cycles.
module hdd_host_xfer #(
    parameter logic [31:0] LBA_BASE       = 32'd0,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_400_000
) (
    input  logic        CLK_14M,
    input  logic        RESET_N,
    input  logic        hdd_read,
    input  logic        hdd_write,
    input  logic [15:0] sector,
    output logic [8:0]  ram_addr,
    output logic [7:0]  ram_di,
    output logic        ram_we,
    input  logic [7:0]  ram_do,
    output logic [31:0] blk_lba,
    output logic        blk_rd,
    output logic        blk_wr,
    input  logic        blk_ack,
    input  logic [7:0]  blk_rx_data,
    input  logic        blk_rx_valid,
    output logic [7:0]  blk_tx_data,
    input  logic        blk_tx_strobe,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_DATA, WR_REQ, WR_PREF, WR_DATA, FIN
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [8:0]  ram_addr_q, ram_addr_d;
    logic [7:0]  ram_di_q, ram_di_d;
    logic        ram_we_q, ram_we_d;
    logic [31:0] blk_lba_q, blk_lba_d;
    logic        blk_rd_q, blk_rd_d;
    logic        blk_wr_q, blk_wr_d;
    logic [7:0]  blk_tx_data_q, blk_tx_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

`ifdef HDD_XFER_TIMEOUT_EN
    logic        error_q, error_d;
    logic [23:0] wdog_q, wdog_d;
`else
    // Watchdog limit has no meaning without the timeout feature.
    logic        unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Next-state and registered-output logic for the transfer FSM.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ram_addr_d    = ram_addr_q;
        ram_di_d      = ram_di_q;
        ram_we_d      = 1'b0;
        blk_lba_d     = blk_lba_q;
        blk_rd_d      = blk_rd_q;
        blk_wr_d      = blk_wr_q;
        blk_tx_data_d = blk_tx_data_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
`ifdef HDD_XFER_TIMEOUT_EN
        error_d       = error_q;
        wdog_d        = 24'd0;
`endif
        case (state_q)
            IDLE: begin
                if (hdd_read || hdd_write) begin
                    blk_lba_d = LBA_BASE + {16'h0, sector};
                    busy_d    = 1'b1;
`ifdef HDD_XFER_TIMEOUT_EN
                    error_d   = 1'b0;
`endif
                    // A simultaneous write is dropped: read has priority.
                    if (hdd_read) begin
                        blk_rd_d = 1'b1;
                        state_d  = RD_REQ;
                    end else begin
                        blk_wr_d = 1'b1;
                        state_d  = WR_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (blk_ack) begin
                    blk_rd_d = 1'b0;
                    cnt_d    = 10'd0;
                    state_d  = RD_DATA;
                end
            end
            RD_DATA: begin
                if (blk_rx_valid) begin
                    ram_addr_d = cnt_q[8:0];
                    ram_di_d   = blk_rx_data;
                    ram_we_d   = 1'b1;
                    cnt_d      = cnt_q + 10'd1;
                    if (cnt_q[8:0] == 9'd511) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (blk_ack) begin
                    blk_wr_d   = 1'b0;
                    cnt_d      = 10'd0;
                    ram_addr_d = 9'd0;
                    state_d    = WR_PREF;
                end
            end
            WR_PREF: begin
                // ram_addr was registered last cycle, so ram_do is valid now.
                blk_tx_data_d = ram_do;
                state_d       = WR_DATA;
            end
            WR_DATA: begin
                if (blk_tx_strobe) begin
                    if (cnt_q == 10'd511) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d      = cnt_q + 10'd1;
                        ram_addr_d = cnt_q[8:0] + 9'd1;
                        state_d    = WR_PREF;
                    end
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef HDD_XFER_TIMEOUT_EN
        // Any device activity restarts the watchdog; expiry aborts via FIN.
        if (state_q != IDLE && state_q != FIN) begin
            if (blk_ack || blk_rx_valid || blk_tx_strobe) begin
                wdog_d = 24'd0;
            end else if (wdog_q + 24'd1 == TIMEOUT_CYCLES) begin
                wdog_d   = 24'd0;
                blk_rd_d = 1'b0;
                blk_wr_d = 1'b0;
                error_d  = 1'b1;
                done_d   = 1'b1;
                state_d  = FIN;
            end else begin
                wdog_d = wdog_q + 24'd1;
            end
        end
`endif
    end

    // State and output registers; reset clears everything except the buffer.
    always_ff @(posedge CLK_14M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= IDLE;
            cnt_q         <= 10'd0;
            ram_addr_q    <= 9'd0;
            ram_di_q      <= 8'd0;
            ram_we_q      <= 1'b0;
            blk_lba_q     <= 32'd0;
            blk_rd_q      <= 1'b0;
            blk_wr_q      <= 1'b0;
            blk_tx_data_q <= 8'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef HDD_XFER_TIMEOUT_EN
            error_q       <= 1'b0;
            wdog_q        <= 24'd0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ram_addr_q    <= ram_addr_d;
            ram_di_q      <= ram_di_d;
            ram_we_q      <= ram_we_d;
            blk_lba_q     <= blk_lba_d;
            blk_rd_q      <= blk_rd_d;
            blk_wr_q      <= blk_wr_d;
            blk_tx_data_q <= blk_tx_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef HDD_XFER_TIMEOUT_EN
            error_q       <= error_d;
            wdog_q        <= wdog_d;
`endif
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_di      = ram_di_q;
    assign ram_we      = ram_we_q;
    assign blk_lba     = blk_lba_q;
    assign blk_rd      = blk_rd_q;
    assign blk_wr      = blk_wr_q;
    assign blk_tx_data = blk_tx_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
`ifdef HDD_XFER_TIMEOUT_EN
    assign error       = error_q;
`else
    assign error       = 1'b0;
`endif

endmodule
